// File: rtl/sh4a_alu_issue.sv
// Issue/writeback front end for the SH-4 ALU: decode, register read, hazard stall, writeback of Rn / SR.T.
// Optional macro SH4A_ALU_ISSUE_FWD_EN: bypass alu_dest into the DEC operand read when the producer is in WB.
module sh4a_alu_issue #(
  parameter int          NREGS     = 16,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_dest,
  input  logic        alu_t,
  output logic        t_out,
  output logic        retire,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  // Opcode values shared with the ALU; 0 is the reset / idle encoding.
  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_CMP_EQ = 6'd3;
  localparam logic [5:0] OP_CMP_HI = 6'd4;
  localparam logic [5:0] OP_CMP_GT = 6'd5;

  typedef struct packed {
    logic       wr;  // writes Rn
    logic       wt;  // writes SR.T
    logic [3:0] n;
  } ctl_t;

  logic [31:0] regs [NREGS];
  logic [1:0]  vld_pipe;  // [0] = EXE, [1] = WB
  ctl_t        exe, wb;

  logic        dec_legal, dec_use_m, dec_wr, dec_wt;
  logic [5:0]  dec_op;
  logic [3:0]  fn, fm;
  logic        exe_n, exe_m, wb_n, wb_m, stall, accept;
  logic [31:0] rn_val, rm_val, imm_sext;

  assign fn       = in_instr[11:8];
  assign fm       = in_instr[7:4];
  assign imm_sext = {{24{in_instr[7]}}, in_instr[7:0]};

  always_comb begin
    dec_legal = 1'b0;
    dec_use_m = 1'b0;
    dec_wr    = 1'b0;
    dec_wt    = 1'b0;
    dec_op    = OP_ADD;
    case (in_instr[15:12])
      4'h3: begin
        dec_use_m = 1'b1;
        case (in_instr[3:0])
          4'hC: begin dec_legal = 1'b1; dec_wr = 1'b1; dec_op = OP_ADD;    end
          4'h8: begin dec_legal = 1'b1; dec_wr = 1'b1; dec_op = OP_SUB;    end
          4'h0: begin dec_legal = 1'b1; dec_wt = 1'b1; dec_op = OP_CMP_EQ; end
          4'h6: begin dec_legal = 1'b1; dec_wt = 1'b1; dec_op = OP_CMP_HI; end
          4'h7: begin dec_legal = 1'b1; dec_wt = 1'b1; dec_op = OP_CMP_GT; end
          default: ;
        endcase
      end
      4'h7: begin dec_legal = 1'b1; dec_wr = 1'b1; dec_op = OP_ADD; end
      default: ;
    endcase
  end

  // RAW matches against GPR-writing instructions; compares never produce a hazard.
  assign exe_n = vld_pipe[0] & exe.wr & (exe.n == fn);
  assign exe_m = vld_pipe[0] & exe.wr & (exe.n == fm) & dec_use_m;
  assign wb_n  = vld_pipe[1] & wb.wr  & (wb.n  == fn);
  assign wb_m  = vld_pipe[1] & wb.wr  & (wb.n  == fm) & dec_use_m;

`ifdef SH4A_ALU_ISSUE_FWD_EN
  assign stall  = in_valid & dec_legal & (exe_n | exe_m);
  assign rn_val = wb_n ? alu_dest : regs[fn];
  assign rm_val = wb_m ? alu_dest : regs[fm];
`else
  assign stall  = in_valid & dec_legal & (exe_n | exe_m | wb_n | wb_m);
  assign rn_val = regs[fn];
  assign rm_val = regs[fm];
`endif

  assign in_ready = rst_n & ~stall;
  assign accept   = in_valid & in_ready;
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      exe      <= '0;
      wb       <= '0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_op   <= '0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      t_out    <= RESET_VAL[0];
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else begin
      vld_pipe[0] <= accept & dec_legal;
      vld_pipe[1] <= vld_pipe[0];
      wb          <= exe;
      retire      <= vld_pipe[1];
      illegal     <= accept & ~dec_legal;
      // ALU inputs hold their last issued values while EXE is empty.
      if (accept & dec_legal) begin
        exe      <= '{wr: dec_wr, wt: dec_wt, n: fn};
        alu_src1 <= rn_val;
        alu_src2 <= dec_use_m ? rm_val : imm_sext;
        alu_op   <= dec_op;
      end
      if (vld_pipe[1]) begin
        if (wb.wr) regs[wb.n] <= alu_dest;
        if (wb.wt) t_out      <= alu_t;
      end
    end
  end
endmodule
